// File: rtl/mult_share_rr_sched_pkg.sv
// Shared constants, width helper and response record for the multiplier-sharing scheduler.
// Optional per-requester grant statistics are enabled with MULT_SHARE_STATS_EN.
package mult_share_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int A_WIDTH_DEF = 64;
  localparam int B_WIDTH_DEF = 64;
  localparam int LAT_DEF     = 3;
  localparam int CNT_W_DEF   = 16;
  localparam int LAT_MIN     = 2;

  // Tag width; a single requester still needs a one-bit tag field.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(NREQ_DEF);

  typedef struct packed {
    logic                                valid;
    logic [ID_W_DEF-1:0]                 id;
    logic [A_WIDTH_DEF+B_WIDTH_DEF-1:0] data;
  } rsp_t;

endpackage

// File: rtl/mult_share_rr_sched_if.sv
// Request/response bus between accelerator clients (master) and the shared multiplier (slave).
// grant_cnt carries live data only when MULT_SHARE_STATS_EN is defined.
interface mult_share_rr_sched_if
  import mult_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*A_WIDTH-1:0] req_a;
  logic [NREQ*B_WIDTH-1:0] req_b;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [A_WIDTH+B_WIDTH-1:0] rsp_data;
  logic [NREQ*CNT_W-1:0]   grant_cnt;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, grant_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, grant_cnt
  );

endinterface

// File: rtl/mult_share_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
// The pointer moves past the winner only when the grant is actually taken (adv).
module mult_share_rr_arb
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  logic [ID_W-1:0] ptr_d, ptr_q;
  logic [ID_W-1:0] cand;
  int              pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = ID_W'(pos);
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_share_rr_sched.sv
// Shares one pipelined unsigned multiplier between NREQ requesters with round-robin
// acceptance and a tagged response bus. Define MULT_SHARE_STATS_EN for saturating grant counters.
module mult_share_rr_sched
  import mult_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int LAT     = LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_rr_sched_if.slave bus
);

  localparam int ID_W    = id_w(NREQ);
  localparam int P_W     = A_WIDTH + B_WIDTH;
  localparam int LAT_EFF = (LAT < LAT_MIN) ? LAT_MIN : LAT;

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            hs;

  logic [A_WIDTH-1:0] a_d, a_q;
  logic [B_WIDTH-1:0] b_d, b_q;
  logic [P_W-1:0]     mul;

  logic [LAT_EFF-1:0] vld_d, vld_q;
  logic [ID_W-1:0]    tag_d  [LAT_EFF];
  logic [ID_W-1:0]    tag_q  [LAT_EFF];
  logic [P_W-1:0]     prod_d [LAT_EFF-1];
  logic [P_W-1:0]     prod_q [LAT_EFF-1];

  assign hs = grant_any & ~rst;

  mult_share_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .adv       (hs),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.req_ready = rst ? '0 : grant;

  assign mul = P_W'(a_q) * P_W'(b_q);

  // Output stage only loads on a valid beat, so rsp_id/rsp_data hold through bubbles.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (hs) begin
      a_d = bus.req_a[int'(grant_idx)*A_WIDTH +: A_WIDTH];
      b_d = bus.req_b[int'(grant_idx)*B_WIDTH +: B_WIDTH];
    end

    vld_d    = {vld_q[LAT_EFF-2:0], hs};
    tag_d[0] = grant_idx;
    for (int k = 1; k < LAT_EFF; k++) tag_d[k] = tag_q[k-1];
    if (!vld_q[LAT_EFF-2]) tag_d[LAT_EFF-1] = tag_q[LAT_EFF-1];

    prod_d[0] = mul;
    for (int j = 1; j < LAT_EFF-1; j++) prod_d[j] = prod_q[j-1];
    if (!vld_q[LAT_EFF-2]) prod_d[LAT_EFF-2] = prod_q[LAT_EFF-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      for (int k = 0; k < LAT_EFF; k++)   tag_q[k]  <= '0;
      for (int j = 0; j < LAT_EFF-1; j++) prod_q[j] <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
      for (int k = 0; k < LAT_EFF; k++)   tag_q[k]  <= tag_d[k];
      for (int j = 0; j < LAT_EFF-1; j++) prod_q[j] <= prod_d[j];
    end
  end

  // Gating with rst hides a product already sitting in the output register.
  assign bus.rsp_valid = vld_q[LAT_EFF-1] & ~rst;
  assign bus.rsp_id    = tag_q[LAT_EFF-1];
  assign bus.rsp_data  = prod_q[LAT_EFF-2];

`ifdef MULT_SHARE_STATS_EN
  logic [CNT_W-1:0] cnt_d [NREQ];
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs && grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign bus.grant_cnt = {(NREQ*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_mult_share_rr_sched.sv
// Scoreboard bench for mult_share_rr_sched: a round-robin reference model predicts grants and
// queued responses; a negedge monitor compares. Grant-counter checks follow MULT_SHARE_STATS_EN.
module tb_mult_share_rr_sched;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 16;
  localparam int LAT  = 3;
  localparam int CW   = 4;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  logic rst_seen;

  int errors;
  int checks;

  logic [AW-1:0]   op_a [NREQ];
  logic [BW-1:0]   op_b [NREQ];
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] exp_ready;
  int              mptr;
  int              mcnt [NREQ];
  exp_t            sb [$];
  logic [31:0]     last_data;
  int              last_id;

  mult_share_rr_sched_if #(.NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW), .CNT_W(CW)) bus ();

  mult_share_rr_sched #(
    .NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW), .LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle: the model picks the winner, queues the product, updates its pointer.
  task automatic apply_stimulus(input logic r, input logic [NREQ-1:0] v);
    int g;
    int c;
    exp_t e;
    g = -1;
    rst = r;
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*AW +: AW] = op_a[i];
      bus.req_b[i*BW +: BW] = op_b[i];
    end
    if (r) begin
      sb.delete();
      mptr = 0;
      for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (mptr + k) % NREQ;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_ready = '0;
    pend = v;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      pend[g] = 1'b0;
      e.due  = cyc + LAT;
      e.id   = g;
      e.data = 32'(op_a[g]) * 32'(op_b[g]);
      sb.push_back(e);
      mptr = (g + 1) % NREQ;
      mcnt[g] = mcnt[g] + 1;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      op_a[g] = AW'($urandom);
      op_b[g] = BW'($urandom);
    end
  endtask

  task automatic check_counters();
    int ex;
    for (int i = 0; i < NREQ; i++) begin
`ifdef MULT_SHARE_STATS_EN
      ex = (mcnt[i] > 15) ? 15 : mcnt[i];
`else
      ex = 0;
`endif
      check_output($sformatf("grant_cnt[%0d]", i), 64'(bus.grant_cnt[i*CW +: CW]), 64'(ex));
    end
  endtask

  // Monitor: compares grant vector every cycle and pops the scoreboard on each response.
  always @(negedge clk) begin
    exp_t e;
    check_output("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (rst) begin
      check_output("rsp_valid_in_reset", 64'(bus.rsp_valid), 64'd0);
      last_data = '0;
      last_id   = 0;
    end
    if (rst_seen) begin
      check_output("rsp_data_after_reset", 64'(bus.rsp_data), 64'd0);
      check_output("rsp_id_after_reset", 64'(bus.rsp_id), 64'd0);
    end
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check_output("unexpected_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_output("rsp_cycle", 64'(cyc), 64'(e.due));
          check_output("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          check_output("rsp_data", 64'(bus.rsp_data), 64'(e.data));
          last_data = e.data;
          last_id   = e.id;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check_output("missing_rsp", 64'(bus.rsp_valid), 64'd1);
        end
        if (!rst_seen) begin
          check_output("rsp_data_hold", 64'(bus.rsp_data), 64'(last_data));
          check_output("rsp_id_hold", 64'(bus.rsp_id), 64'(last_id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NREQ-1:0] v;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    exp_ready = '0;
    pend = '0;
    mptr = 0;
    last_data = '0;
    last_id = 0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = AW'($urandom);
      op_b[i] = BW'($urandom);
      mcnt[i] = 0;
    end

    $display("[TB] reset with all requesters valid");
    apply_stimulus(1'b1, 4'b1111);
    apply_stimulus(1'b1, 4'b1111);
    check_counters();

    $display("[TB] fairness: all valid for 8 cycles");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0000);

    $display("[TB] single max operands on requester 2");
    op_a[2] = 16'hFFFF;
    op_b[2] = 16'hFFFF;
    apply_stimulus(1'b0, 4'b0100);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0000);

    $display("[TB] gaps: req 1, idle, req 3");
    apply_stimulus(1'b0, 4'b0010);
    apply_stimulus(1'b0, 4'b0000);
    apply_stimulus(1'b0, 4'b1000);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4'b0000);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'b0001);
    apply_stimulus(1'b1, 4'b1111);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4'b0000);
    apply_stimulus(1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0000);

    $display("[TB] requester 0 alone for 20 cycles");
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 4'b0001);
    check_counters();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      v = pend | NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      apply_stimulus(i == 200, v);
    end
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 4'b0000);
    check_counters();
    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
